counter_dir_decoder: RTL and testbench

Receiving end of the 2-bit up/down counter interface. Samples a free-running 2-bit count value and recovers the step direction (the counter's `up` input) from consecutive samples. It also tracks an extended signed position and flags illegal jumps. It sits downstream of counter_2bit, for example on the far side of a link or in a checker, where only the 2-bit count is visible.

---
 rtl/counter_dir_decoder.sv | 147 ++++++++++++++
 tb/tb_counter_dir_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/counter_dir_decoder.sv
// Receiving side of the 2-bit up/down counter link: recovers step direction,
// an extended signed position, an idle indication and a sticky illegal-jump error.
module counter_dir_decoder #(
   parameter int POS_W    = 16,
   parameter int IDLE_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cnt_in,
   input  logic             cnt_valid,
   input  logic             clr_err,
   output logic             up,
   output logic             step,
   output logic             dir_chg,
   output logic [POS_W-1:0] pos,
   output logic             locked,
   output logic             idle,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'b00,
      ST_LOCKED   = 2'b01,
      ST_ERROR    = 2'b10
   } state_t;

   localparam logic [7:0]       IDLE_MAX_C = 8'(IDLE_MAX);
   localparam logic [POS_W-1:0] POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_nxt_s;
   logic [1:0]       prev_r, prev_nxt_s;
   logic [1:0]       delta_s;
   logic [POS_W-1:0] pos_r, pos_nxt_s;
   logic [7:0]       idle_cnt_r, idle_cnt_nxt_s;
   logic             up_r, up_nxt_s;
   logic             step_r, step_nxt_s;
   logic             dir_chg_r, dir_chg_nxt_s;
   logic             locked_r, idle_r, err_r, err_nxt_s;

   assign delta_s = cnt_in - prev_r;

   // Next-state and next-output decode; pulses default low, everything else holds.
   always_comb begin
      state_nxt_s    = state_r;
      prev_nxt_s     = prev_r;
      pos_nxt_s      = pos_r;
      idle_cnt_nxt_s = idle_cnt_r;
      up_nxt_s       = up_r;
      step_nxt_s     = 1'b0;
      dir_chg_nxt_s  = 1'b0;
      err_nxt_s      = err_r;
      case (state_r)
         ST_UNLOCKED: begin
            if (cnt_valid) begin
               prev_nxt_s  = cnt_in;
               state_nxt_s = ST_LOCKED;
            end else begin
               state_nxt_s = ST_UNLOCKED;
            end
         end
         ST_LOCKED: begin
            if (cnt_valid) begin
               case (delta_s)
                  2'd1: begin
                     pos_nxt_s      = pos_r + POS_ONE;
                     up_nxt_s       = 1'b1;
                     step_nxt_s     = 1'b1;
                     dir_chg_nxt_s  = ~up_r;
                     prev_nxt_s     = cnt_in;
                     idle_cnt_nxt_s = 8'd0;
                  end
                  2'd3: begin
                     pos_nxt_s      = pos_r - POS_ONE;
                     up_nxt_s       = 1'b0;
                     step_nxt_s     = 1'b1;
                     dir_chg_nxt_s  = up_r;
                     prev_nxt_s     = cnt_in;
                     idle_cnt_nxt_s = 8'd0;
                  end
                  2'd0: begin
                     if (idle_cnt_r < IDLE_MAX_C) begin
                        idle_cnt_nxt_s = idle_cnt_r + 8'd1;
                     end else begin
                        idle_cnt_nxt_s = IDLE_MAX_C;
                     end
                  end
                  default: begin
                     // A jump of two leaves direction ambiguous; freeze and flag.
                     state_nxt_s = ST_ERROR;
                     err_nxt_s   = 1'b1;
                  end
               endcase
            end else begin
               state_nxt_s = ST_LOCKED;
            end
         end
         ST_ERROR: begin
            if (clr_err) begin
               state_nxt_s    = ST_UNLOCKED;
               err_nxt_s      = 1'b0;
               idle_cnt_nxt_s = 8'd0;
            end else begin
               state_nxt_s = ST_ERROR;
            end
         end
         default: begin
            state_nxt_s = ST_UNLOCKED;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_UNLOCKED;
         prev_r     <= 2'd0;
         pos_r      <= {POS_W{1'b0}};
         idle_cnt_r <= 8'd0;
         up_r       <= 1'b1;
         step_r     <= 1'b0;
         dir_chg_r  <= 1'b0;
         locked_r   <= 1'b0;
         idle_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         prev_r     <= prev_nxt_s;
         pos_r      <= pos_nxt_s;
         idle_cnt_r <= idle_cnt_nxt_s;
         up_r       <= up_nxt_s;
         step_r     <= step_nxt_s;
         dir_chg_r  <= dir_chg_nxt_s;
         locked_r   <= (state_nxt_s == ST_LOCKED);
         idle_r     <= (idle_cnt_nxt_s == IDLE_MAX_C);
         err_r      <= err_nxt_s;
      end
   end

   assign up      = up_r;
   assign step    = step_r;
   assign dir_chg = dir_chg_r;
   assign pos     = pos_r;
   assign locked  = locked_r;
   assign idle    = idle_r;
   assign err     = err_r;

endmodule

// File: tb/tb_counter_dir_decoder.sv
// Directed self-checking bench: default-parameter instance "a" and a small
// instance "b" (POS_W=4, IDLE_MAX=3) driven from the same stimulus.
module tb_counter_dir_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  cnt_in = 2'd0;
   logic        cnt_valid = 1'b0;
   logic        clr_err = 1'b0;

   logic        up_a, step_a, dir_chg_a, locked_a, idle_a, err_a;
   logic [15:0] pos_a;
   logic        up_b, step_b, dir_chg_b, locked_b, idle_b, err_b;
   logic [3:0]  pos_b;

   int vectors = 0;
   int miscompares = 0;

   counter_dir_decoder #(.POS_W(16), .IDLE_MAX(15)) dut_a (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_err(clr_err),
      .up(up_a), .step(step_a), .dir_chg(dir_chg_a), .pos(pos_a),
      .locked(locked_a), .idle(idle_a), .err(err_a)
   );

   counter_dir_decoder #(.POS_W(4), .IDLE_MAX(3)) dut_b (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_err(clr_err),
      .up(up_b), .step(step_b), .dir_chg(dir_chg_b), .pos(pos_b),
      .locked(locked_b), .idle(idle_b), .err(err_b)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic send(input logic v, input logic [1:0] c, input logic clr);
      cnt_valid = v;
      cnt_in    = c;
      clr_err   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      send(1'b0, 2'd0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if ({up_a, step_a, dir_chg_a, locked_a, idle_a, err_a} !== 6'b100000) begin
         miscompares++; $display("FAIL reset_flags: got %b exp 100000", {up_a, step_a, dir_chg_a, locked_a, idle_a, err_a}); end
      vectors++; if (pos_a !== 16'h0000) begin
         miscompares++; $display("FAIL reset_pos: got %h exp 0000", pos_a); end
   endtask

   task automatic test_up_count();
      logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      send(1'b1, 2'd0, 1'b0);
      vectors++; if ({locked_a, step_a, pos_a} !== {1'b1, 1'b0, 16'h0000}) begin
         miscompares++; $display("FAIL up_lock: got locked=%b step=%b pos=%h exp 1 0 0000", locked_a, step_a, pos_a); end
      for (int k = 0; k < 4; k++) begin
         send(1'b1, seq[k], 1'b0);
         vectors++; if ({step_a, up_a, dir_chg_a, err_a} !== 4'b1100) begin
            miscompares++; $display("FAIL up_step%0d: got step,up,dchg,err=%b exp 1100", k, {step_a, up_a, dir_chg_a, err_a}); end
         vectors++; if (pos_a !== 16'(k + 1)) begin
            miscompares++; $display("FAIL up_pos%0d: got %h exp %h", k, pos_a, 16'(k + 1)); end
      end
      send(1'b0, 2'd2, 1'b0);
      vectors++; if ({step_a, pos_a} !== {1'b0, 16'h0004}) begin
         miscompares++; $display("FAIL up_invalid: got step=%b pos=%h exp 0 0004", step_a, pos_a); end
   endtask

   task automatic test_down();
      logic [1:0]  seq  [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
      logic        eup  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic        edc  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] epos [4] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFE};
      do_reset();
      send(1'b1, 2'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         send(1'b1, seq[k], 1'b0);
         vectors++; if ({step_a, up_a, dir_chg_a} !== {1'b1, eup[k], edc[k]}) begin
            miscompares++; $display("FAIL down_flags%0d: got step,up,dchg=%b exp %b", k, {step_a, up_a, dir_chg_a}, {1'b1, eup[k], edc[k]}); end
         vectors++; if (pos_a !== epos[k]) begin
            miscompares++; $display("FAIL down_pos%0d: got %h exp %h", k, pos_a, epos[k]); end
      end
   endtask

   task automatic test_error();
      do_reset();
      send(1'b1, 2'd0, 1'b0);
      send(1'b1, 2'd1, 1'b0);
      send(1'b1, 2'd3, 1'b0);
      vectors++; if ({err_a, locked_a, step_a, up_a, pos_a} !== {4'b1001, 16'h0001}) begin
         miscompares++; $display("FAIL err_set: got err,lock,step,up=%b pos=%h exp 1001 0001", {err_a, locked_a, step_a, up_a}, pos_a); end
      send(1'b1, 2'd0, 1'b0);
      vectors++; if ({err_a, step_a, pos_a} !== {2'b10, 16'h0001}) begin
         miscompares++; $display("FAIL err_ignore: got err,step=%b pos=%h exp 10 0001", {err_a, step_a}, pos_a); end
      send(1'b1, 2'd2, 1'b1);
      vectors++; if ({err_a, locked_a, step_a} !== 3'b000) begin
         miscompares++; $display("FAIL err_clear: got err,lock,step=%b exp 000", {err_a, locked_a, step_a}); end
      send(1'b1, 2'd2, 1'b0);
      vectors++; if ({locked_a, step_a, pos_a} !== {2'b10, 16'h0001}) begin
         miscompares++; $display("FAIL err_relock: got lock,step=%b pos=%h exp 10 0001", {locked_a, step_a}, pos_a); end
      send(1'b1, 2'd3, 1'b0);
      vectors++; if ({step_a, pos_a} !== {1'b1, 16'h0002}) begin
         miscompares++; $display("FAIL err_after_relock: got step=%b pos=%h exp 1 0002", step_a, pos_a); end
      send(1'b1, 2'd0, 1'b1);
      vectors++; if ({step_a, err_a, locked_a, pos_a} !== {3'b101, 16'h0003}) begin
         miscompares++; $display("FAIL clr_in_locked: got step,err,lock=%b pos=%h exp 101 0003", {step_a, err_a, locked_a}, pos_a); end
   endtask

   task automatic test_idle();
      logic       v    [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [1:0] c    [6] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2};
      logic       eidl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      send(1'b1, 2'd1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         send(v[k], c[k], 1'b0);
         vectors++; if (idle_b !== eidl[k]) begin
            miscompares++; $display("FAIL idle_b%0d: got %b exp %b", k, idle_b, eidl[k]); end
      end
      vectors++; if ({idle_a, step_b, pos_b} !== {2'b01, 4'h1}) begin
         miscompares++; $display("FAIL idle_a_step: got idle_a,step_b=%b pos_b=%h exp 01 1", {idle_a, step_b}, pos_b); end
   endtask

   task automatic test_wrap();
      do_reset();
      send(1'b1, 2'd0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         send(1'b1, 2'(k + 1), 1'b0);
         vectors++; if (pos_b !== 4'(k + 1)) begin
            miscompares++; $display("FAIL wrap_up%0d: got %h exp %h", k, pos_b, 4'(k + 1)); end
      end
      vectors++; if (pos_a !== 16'h0008) begin
         miscompares++; $display("FAIL wrap_wide: got %h exp 0008", pos_a); end
      send(1'b1, 2'd3, 1'b0);
      vectors++; if ({pos_b, dir_chg_b, up_b} !== {4'h7, 2'b10}) begin
         miscompares++; $display("FAIL wrap_down: got pos=%h dchg,up=%b exp 7 10", pos_b, {dir_chg_b, up_b}); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      send(1'b1, 2'd0, 1'b0);
      for (int k = 0; k < 5; k++) send(1'b1, seq[k], 1'b0);
      send(1'b1, 2'd3, 1'b0);
      vectors++; if ({err_a, pos_a} !== {1'b1, 16'h0005}) begin
         miscompares++; $display("FAIL mid_pre: got err=%b pos=%h exp 1 0005", err_a, pos_a); end
      rst = 1'b1;
      send(1'b1, 2'd2, 1'b0);
      rst = 1'b0;
      vectors++; if ({up_a, step_a, dir_chg_a, locked_a, idle_a, err_a, pos_a} !== {6'b100000, 16'h0000}) begin
         miscompares++; $display("FAIL mid_reset: got flags=%b pos=%h exp 100000 0000", {up_a, step_a, dir_chg_a, locked_a, idle_a, err_a}, pos_a); end
      send(1'b1, 2'd2, 1'b0);
      vectors++; if ({locked_a, step_a, pos_a} !== {2'b10, 16'h0000}) begin
         miscompares++; $display("FAIL mid_relock: got lock,step=%b pos=%h exp 10 0000", {locked_a, step_a}, pos_a); end
      send(1'b1, 2'd3, 1'b0);
      vectors++; if ({step_a, dir_chg_a, pos_a} !== {2'b10, 16'h0001}) begin
         miscompares++; $display("FAIL mid_step: got step,dchg=%b pos=%h exp 10 0001", {step_a, dir_chg_a}, pos_a); end
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down();
      test_error();
      test_idle();
      test_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
